// File: rtl/barrett_correct.sv
// Final-correction stage of the Barrett multiplier: reduces r in [0, 3M) to r mod M
// by at most two conditional subtractions, returned over a valid/ready handshake.
module barrett_correct #(
   parameter int unsigned N = 1024
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         in_valid,
   output logic         in_ready,
   input  logic [N+1:0] r_in,
   input  logic [N-1:0] m_in,
   output logic         out_valid,
   input  logic         out_ready,
   output logic [N-1:0] res_out,
   output logic         out_err
);

   typedef enum logic [1:0] {StIdle, StIter, StDone} state_e;

   state_e         state_q, state_d;
   logic [N+1:0]   r_q, r_d;
   logic [N-1:0]   m_q, m_d;
   logic [1:0]     cnt_q, cnt_d;
   logic [N-1:0]   res_q, res_d;
   logic           err_q, err_d;

   logic [N+1:0]   op_b;
   logic [N+1:0]   diff;
   logic           carry;
   logic           ge;

   assign op_b = ~{2'b00, m_q};

   // Ripple add r + ~M + 1; the final carry-out is the r >= M compare.
   always_comb begin
      carry = 1'b1;
      diff  = '0;
      for (int i = 0; i < N + 2; i++) begin
         diff[i] = r_q[i] ^ op_b[i] ^ carry;
         carry   = (r_q[i] & op_b[i]) | ((r_q[i] ^ op_b[i]) & carry);
      end
      ge = carry;
   end

   // rst gates in_ready so no input is taken while reset is held.
   assign in_ready  = (state_q == StIdle) && !rst;
   assign out_valid = (state_q == StDone);
   assign res_out   = res_q;
   assign out_err   = err_q;

   always_comb begin
      state_d = state_q;
      r_d     = r_q;
      m_d     = m_q;
      cnt_d   = cnt_q;
      res_d   = res_q;
      err_d   = err_q;
      unique case (state_q)
         StIdle: begin
            if (in_valid) begin
               r_d     = r_in;
               m_d     = m_in;
               cnt_d   = 2'd0;
               state_d = StIter;
            end
         end
         StIter: begin
            if (!ge) begin
               res_d   = r_q[N-1:0];
               err_d   = 1'b0;
               state_d = StDone;
            end else if (cnt_q != 2'd2) begin
               r_d   = diff;
               cnt_d = cnt_q + 2'd1;
            end else begin
               res_d   = r_q[N-1:0];
               err_d   = 1'b1;
               state_d = StDone;
            end
         end
         StDone: begin
            if (out_ready) begin
               state_d = StIdle;
            end
         end
         default: state_d = StIdle;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= StIdle;
         r_q     <= '0;
         m_q     <= '0;
         cnt_q   <= 2'd0;
         res_q   <= '0;
         err_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         r_q     <= r_d;
         m_q     <= m_d;
         cnt_q   <= cnt_d;
         res_q   <= res_d;
         err_q   <= err_d;
      end
   end

endmodule

// File: tb/tb_barrett_correct.sv
// Directed bench for barrett_correct at N = 8, with an arithmetic reference model
// checked on every cycle out_valid is high.
module tb_barrett_correct;

   localparam int unsigned N = 8;

   logic         clk = 1'b0;
   logic         rst;
   logic         in_valid;
   logic         in_ready;
   logic [N+1:0] r_in;
   logic [N-1:0] m_in;
   logic         out_valid;
   logic         out_ready;
   logic [N-1:0] res_out;
   logic         out_err;

   int checks = 0;
   int errors = 0;

   bit exp_valid = 1'b0;
   int exp_res_m = 0;
   int exp_err_m = 0;

   barrett_correct #(.N(N)) dut (
      .clk       (clk),
      .rst       (rst),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .r_in      (r_in),
      .m_in      (m_in),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .res_out   (res_out),
      .out_err   (out_err)
   );

   always #5 clk = ~clk;

   task automatic check(input string name, input int act, input int exp);
      checks++;
      if (act != exp) begin
         errors++;
         $display("FAIL %s: got %0d, expected %0d", name, act, exp);
      end
   endtask

   // Reduce by at most two subtractions; error if still not below M.
   function automatic void model(input int r, input int m, output int res, output int err,
                                 output int k);
      int rr = r;
      k = 0;
      while (rr >= m && k < 2) begin
         rr -= m;
         k++;
      end
      err = (rr >= m) ? 1 : 0;
      res = rr % 256;
   endfunction

   always @(negedge clk) begin
      if (!rst && out_valid) begin
         checks++;
         if (!exp_valid || res_out != exp_res_m[N-1:0] || int'(out_err) != exp_err_m) begin
            errors++;
            $display("FAIL model_cmp: got res=%0d err=%0d, expected res=%0d err=%0d (pending=%0d)",
                     res_out, out_err, exp_res_m, exp_err_m, exp_valid);
         end
      end
   end

   task automatic do_op(input string name, input int r, input int m, input int exp_res,
                        input int exp_err, input int exp_lat, input int hold);
      int mres, merr, mk;
      int lat;
      out_ready = 1'b0;
      @(negedge clk);
      check({name, "_in_ready"}, int'(in_ready), 1);
      in_valid = 1'b1;
      r_in     = r[N+1:0];
      m_in     = m[N-1:0];
      model(r, m, mres, merr, mk);
      check({name, "_model_lat"}, mk + 1, exp_lat);
      @(posedge clk);
      exp_res_m = mres;
      exp_err_m = merr;
      exp_valid = 1'b1;
      #1;
      in_valid = 1'b0;
      lat = 0;
      for (int i = 1; i <= 10; i++) begin
         @(posedge clk);
         #1;
         if (out_valid) begin
            lat = i;
            break;
         end
      end
      check({name, "_latency"}, lat, exp_lat);
      check({name, "_res"}, int'(res_out), exp_res);
      check({name, "_err"}, int'(out_err), exp_err);
      for (int i = 0; i < hold; i++) begin
         in_valid = 1'b1;
         r_in     = 10'd5;
         @(posedge clk);
         #1;
         check({name, "_stall_valid"}, int'(out_valid), 1);
         check({name, "_stall_res"}, int'(res_out), exp_res);
         check({name, "_stall_in_ready"}, int'(in_ready), 0);
      end
      in_valid  = 1'b0;
      out_ready = 1'b1;
      @(posedge clk);
      #1;
      exp_valid = 1'b0;
      out_ready = 1'b0;
      check({name, "_post_valid"}, int'(out_valid), 0);
      check({name, "_post_in_ready"}, int'(in_ready), 1);
      check({name, "_post_res_kept"}, int'(res_out), exp_res);
   endtask

   initial begin
      rst       = 1'b1;
      in_valid  = 1'b0;
      out_ready = 1'b0;
      r_in      = '0;
      m_in      = '0;
      repeat (2) @(posedge clk);
      #1;
      check("reset_out_valid", int'(out_valid), 0);
      check("reset_res", int'(res_out), 0);
      check("reset_err", int'(out_err), 0);
      check("reset_in_ready", int'(in_ready), 0);
      rst = 1'b0;
      #1;
      check("post_reset_in_ready", int'(in_ready), 1);

      do_op("r150", 150, 200, 150, 0, 1, 0);
      do_op("r200", 200, 200, 0, 0, 2, 0);
      do_op("r450", 450, 200, 50, 0, 3, 0);
      do_op("r700", 700, 200, 44, 1, 3, 0);
      do_op("r399_stall", 399, 200, 199, 0, 2, 5);
      do_op("m0", 77, 0, 77, 1, 3, 0);

      // Abort an operation while it is iterating.
      @(negedge clk);
      in_valid = 1'b1;
      r_in     = 10'd450;
      m_in     = 8'd200;
      @(posedge clk);
      #1;
      in_valid = 1'b0;
      rst      = 1'b1;
      @(posedge clk);
      #1;
      check("abort_out_valid", int'(out_valid), 0);
      check("abort_res", int'(res_out), 0);
      check("abort_err", int'(out_err), 0);
      check("abort_in_ready", int'(in_ready), 0);
      rst = 1'b0;
      #1;
      check("abort_release_in_ready", int'(in_ready), 1);
      do_op("after_rst", 10, 200, 10, 0, 1, 0);

      repeat (2) @(posedge clk);
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
